instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the multicycle CPU: owns the program counter, issues word requests to instruction memory, and holds the fetched instruction stable for the control unit and datapath until the current instruction commits. At commit it computes the next PC from the decoded `PCchoose` code (sequential, branch, register, jump) and the ALU branch outcome. It also supplies the return address to the `jal` link path.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  one-cycle request pulse to instruction memory.
- `imem_addr`  out  32  word address of the request; equals `pc`.
- `imem_valid`  in  1  instruction memory response strobe.
- `imem_rdata`  in  32  instruction word, valid with `imem_valid`.
- `instr`  out  32  registered instruction to the control unit.
- `instr_valid`  out  1  `instr` holds a live instruction.
- `pc`  out  32  address of `instr`.
- `link_pc`  out  32  `pc + 4`, written to register 31 by `jal`.
- `commit`  in  1  current instruction has finished execution; the PC may advance.
- `pc_choose`  in  2  from the control unit: 0 seq, 1 branch, 2 register, 3 jump.
- `imm`  in  32  sign- or zero-extended immediate from the control unit.
- `branch_taken`  in  1  ALU compare result for the current branch.
- `reg_target`  in  32  rs value, used by `jr`.
- `align_fault`  out  1  sticky flag: a misaligned `jr` target was seen.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset. Moves to REQ unconditionally on the next cycle.
- REQ: `imem_req=1` and `imem_addr=pc` for exactly one cycle, then WAIT.
- WAIT: on `imem_valid=1`, load `instr<=imem_rdata`, set `instr_valid<=1`, go to HOLD. Otherwise stay in WAIT with `imem_req=0`.
- HOLD: `instr` and `pc` are frozen. On `commit=1`, load `pc<=next_pc`, clear `instr_valid`, go to REQ.
- `next_pc` by `pc_choose`:
  - 0: `pc+4`.
  - 1: `pc + (imm<<2)` if `branch_taken`, else `pc+4`.
  - 2: `{reg_target[31:2],2'b00}`. If `reg_target[1:0]!=0`, set `align_fault`.
  - 3: `{pc[31:28], instr[25:0], 2'b00}`.
- All arithmetic is 32-bit modulo 2^32. `pc+4` from 32'hFFFF_FFFC wraps to 0. Branch offsets wrap the same way.
- `align_fault` stays set until `rst`.
- `link_pc` is combinational from `pc`.

## Timing
- Reset values: `pc=RESET_PC`, `instr=0` (NOP), `instr_valid=0`, `imem_req=0`, `align_fault=0`, state IDLE.
- `rst` wins over every other input in the same cycle, including mid-WAIT and mid-HOLD. The in-flight memory response is then discarded.
- After `rst` deasserts (first cycle without reset = cycle 0): IDLE at cycle 0, `imem_req` at cycle 1.
- Minimum fetch latency is 1 cycle: `imem_valid` in the cycle after REQ gives `instr_valid` on the next edge.
- `imem_valid` is ignored outside WAIT. A stray response during REQ, IDLE or HOLD changes nothing.
- `commit` is ignored outside HOLD. Commit-to-next-`imem_req` is exactly 1 cycle.
- `pc_choose`, `imm`, `branch_taken` and `reg_target` are sampled only in the cycle where `commit=1` in HOLD.
- `instr` is held for the entire HOLD period regardless of other inputs.

## Structure
- Shared package `cpu_pkg`:
  - `PCchoose` encodings: `PC_SEQ=0`, `PC_BRANCH=1`, `PC_REG=2`, `PC_JUMP=3`.
  - Fetch state enum.
  - `NOP_INSTR=32'h0`.
- One combinational sub-module, `next_pc_calc`:
  - inputs `pc`, `instr`, `pc_choose`, `imm`, `branch_taken`, `reg_target`;
  - outputs `next_pc`, `misaligned`.
- The FSM, PC register and instruction register live in the top.

## Test plan
- Reset with `RESET_PC=32'h100`:
  - `pc=0x100`, `instr_valid=0`, `imem_req=1` at cycle 1 with addr 0x100.
  - `imem_valid` with data 0x0000_0820 one cycle later gives `instr=0x0000_0820`, `instr_valid=1`.
- Sequential:
  - `pc=0x100`, commit with `pc_choose=0` gives next request at 0x104.
  - `pc=0xFFFF_FFFC` wraps to 0x0.
- Branch at `pc=0x200`, `imm=32'hFFFF_FFFE`:
  - `branch_taken=1` gives `pc=0x1F8`.
  - `branch_taken=0` gives `pc=0x204`.
- Jump and jr:
  - `pc=0x1000_0000`, `instr=0x0800_0040`, `pc_choose=3` gives `pc=0x1000_0100`.
  - `pc_choose=2`, `reg_target=0x306` gives `pc=0x304` and `align_fault=1`, still set after three further commits.
- Protocol:
  - `imem_valid` pulsed in HOLD leaves `instr` unchanged.
  - `commit` in WAIT is ignored.
  - `imem_valid` delayed 5 cycles keeps `imem_req=0` throughout WAIT.
- Reset mid-WAIT:
  - `rst` during WAIT, with `imem_valid` in the same cycle, gives `pc=RESET_PC`, `instr=0`, `instr_valid=0` and state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and constants shared by the multicycle CPU blocks.
// Holds the PC-source encodings, the fetch FSM states and small address helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_REG    = 2'd2,
        PC_JUMP   = 2'd3
    } pc_choose_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// The fetch unit is the master: it issues req/addr and receives valid/rdata.
interface instr_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  valid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output valid,
        output rdata
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch unit.
// Flags a misaligned register target; the caller decides when to latch it.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  pc_choose,
    input  logic [31:0] imm,
    input  logic        branch_taken,
    input  logic [31:0] reg_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic        unused_opcode;

    assign seq_pc        = pc + PC_STEP;
    assign branch_pc     = pc + (imm << 2);
    assign jump_pc       = {pc[31:28], instr[25:0], 2'b00};
    // Opcode field is decoded by the control unit, not here.
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        next_pc    = seq_pc;
        misaligned = 1'b0;
        unique case (pc_choose)
            PC_SEQ:    next_pc = seq_pc;
            PC_BRANCH: next_pc = branch_taken ? branch_pc : seq_pc;
            PC_REG: begin
                next_pc    = word_align(reg_target);
                misaligned = (reg_target[1:0] != 2'b00);
            end
            PC_JUMP:   next_pc = jump_pc;
            default:   next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction and holds it until commit.
// The PC only advances at commit in HOLD, so the instruction and its address stay paired.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               instr,
    output logic                      instr_valid,
    output logic [31:0]               pc,
    output logic [31:0]               link_pc,
    input  logic                      commit,
    input  logic [1:0]                pc_choose,
    input  logic [31:0]               imm,
    input  logic                      branch_taken,
    input  logic [31:0]               reg_target,
    output logic                      align_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         align_fault_q, align_fault_d;

    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_calc u_next_pc_calc (
        .pc           (pc_q),
        .instr        (instr_q),
        .pc_choose    (pc_choose),
        .imm          (imm),
        .branch_taken (branch_taken),
        .reg_target   (reg_target),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= word_align(RESET_PC);
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            align_fault_q <= align_fault_d;
        end
    end

    // Responses and commits outside their own state fall through the defaults untouched.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        align_fault_d = align_fault_q;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq:  state_d = StWait;
            StWait: begin
                if (imem.valid) begin
                    instr_d       = imem.rdata;
                    instr_valid_d = 1'b1;
                    state_d       = StHold;
                end
            end
            StHold: begin
                if (commit) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    align_fault_d = align_fault_q | misaligned;
                    state_d       = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign imem.req    = (state_q == StReq);
    assign imem.addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign link_pc     = pc_q + PC_STEP;
    assign align_fault = align_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed corner cases plus randomized
// fetch/commit transactions checked against a transaction-level PC model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RstPc = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_pc;
    logic        commit;
    logic [1:0]  pc_choose;
    logic [31:0] imm;
    logic        branch_taken;
    logic [31:0] reg_target;
    logic        align_fault;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [31:0] m_pc;
    logic        m_fault;

    instr_fetch_unit_if imem ();

    instr_fetch_unit #(
        .RESET_PC (RstPc)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .link_pc      (link_pc),
        .commit       (commit),
        .pc_choose    (pc_choose),
        .imm          (imm),
        .branch_taken (branch_taken),
        .reg_target   (reg_target),
        .align_fault  (align_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Applies reset for one edge (optionally with a colliding response), then checks
    // the reset values and the IDLE -> REQ timing.
    task automatic do_reset(input logic with_valid);
        rst        = 1'b1;
        commit     = 1'b0;
        imem.valid = with_valid;
        imem.rdata = $urandom;
        step();
        check_eq("rst_pc", pc, RstPc);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rst_req", {31'b0, imem.req}, 32'd0);
        check_eq("rst_fault", {31'b0, align_fault}, 32'd0);
        rst        = 1'b0;
        imem.valid = 1'b0;
        check_eq("cycle0_req", {31'b0, imem.req}, 32'd0);
        step();
        check_eq("cycle1_req", {31'b0, imem.req}, 32'd1);
        check_eq("cycle1_addr", imem.addr, RstPc);
        m_pc    = RstPc;
        m_fault = 1'b0;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic [1:0] ch, input logic [31:0] im,
                                               input logic tk, input logic [31:0] rt);
        case (ch)
            2'd0:    return cur + 32'd4;
            2'd1:    return tk ? cur + im * 32'd4 : cur + 32'd4;
            2'd2:    return rt & 32'hFFFF_FFFC;
            default: return (cur & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        endcase
    endfunction

    // One full transaction: request, response after `delay` idle WAIT cycles, a random
    // HOLD period with stray responses, then a commit with the given PC source.
    task automatic fetch(input logic [31:0] data, input int delay, input logic [1:0] ch,
                         input logic [31:0] im, input logic tk, input logic [31:0] rt,
                         input logic stray);
        int n;
        int hold;
        n = 0;
        while (!imem.req && n < 20) begin
            step();
            n++;
        end
        check_eq("req_seen", {31'b0, imem.req}, 32'd1);
        check_eq("req_addr", imem.addr, m_pc);
        imem.valid = stray;
        imem.rdata = ~data;
        step();
        imem.valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            commit = 1'($urandom_range(0, 1));
            check_eq("wait_req", {31'b0, imem.req}, 32'd0);
            step();
        end
        check_eq("wait_req", {31'b0, imem.req}, 32'd0);
        commit     = 1'($urandom_range(0, 1));
        imem.valid = 1'b1;
        imem.rdata = data;
        step();
        imem.valid = 1'b0;
        commit     = 1'b0;
        check_eq("hold_instr", instr, data);
        check_eq("hold_valid", {31'b0, instr_valid}, 32'd1);
        check_eq("hold_pc", pc, m_pc);
        check_eq("link_pc", link_pc, m_pc + 32'd4);
        hold = int'($urandom_range(0, 3));
        for (int i = 0; i < hold; i++) begin
            imem.valid = 1'($urandom_range(0, 1));
            imem.rdata = $urandom;
            step();
            imem.valid = 1'b0;
            check_eq("hold_stable", instr, data);
            check_eq("hold_no_req", {31'b0, imem.req}, 32'd0);
        end
        commit       = 1'b1;
        pc_choose    = ch;
        imm          = im;
        branch_taken = tk;
        reg_target   = rt;
        if (ch == 2'd2 && rt[1:0] != 2'b00) m_fault = 1'b1;
        m_pc = model_next(m_pc, data, ch, im, tk, rt);
        step();
        commit       = 1'b0;
        pc_choose    = 2'($urandom);
        imm          = $urandom;
        branch_taken = 1'($urandom);
        reg_target   = $urandom;
        check_eq("commit_req", {31'b0, imem.req}, 32'd1);
        check_eq("commit_addr", imem.addr, m_pc);
        check_eq("commit_clr_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("fault", {31'b0, align_fault}, {31'b0, m_fault});
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        commit       = 1'b0;
        pc_choose    = 2'd0;
        imm          = 32'h0;
        branch_taken = 1'b0;
        reg_target   = 32'h0;
        imem.valid   = 1'b0;
        imem.rdata   = 32'h0;
        m_pc         = RstPc;
        m_fault      = 1'b0;
        step();
        do_reset(1'b0);

        fetch(32'h0000_0820, 0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("seq_pc", pc, 32'h104);
        fetch(32'h0000_0000, 5, 2'd2, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        fetch(32'h0000_0000, 1, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("wrap_pc", pc, 32'h0);
        fetch(32'h1234_5678, 0, 2'd2, 32'h0, 1'b0, 32'h200, 1'b0);
        fetch(32'h1234_5678, 2, 2'd1, 32'hFFFF_FFFE, 1'b1, 32'h0, 1'b0);
        check_eq("br_taken_pc", pc, 32'h1F8);
        fetch(32'h1234_5678, 0, 2'd2, 32'h0, 1'b0, 32'h200, 1'b0);
        fetch(32'h1234_5678, 0, 2'd1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
        check_eq("br_not_taken_pc", pc, 32'h204);
        fetch(32'h0, 0, 2'd2, 32'h0, 1'b0, 32'h1000_0000, 1'b0);
        fetch(32'h0800_0040, 3, 2'd3, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("jump_pc", pc, 32'h1000_0100);
        fetch(32'h0, 0, 2'd2, 32'h0, 1'b0, 32'h306, 1'b0);
        check_eq("jr_pc", pc, 32'h304);
        check_eq("jr_fault", {31'b0, align_fault}, 32'd1);
        for (int i = 0; i < 3; i++) fetch($urandom, 0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("fault_sticky", {31'b0, align_fault}, 32'd1);

        // Reset landing in WAIT together with a response.
        step();
        do_reset(1'b1);

        for (int t = 0; t < 40; t++) begin
            fetch($urandom, int'($urandom_range(0, 4)), 2'($urandom), $urandom,
                  1'($urandom), $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
